// File: rtl/key_xd.sv
// -----------------------------------------------------------------------------
// key_xd : push-button debouncer for a single active-low mechanical key.
//
// The raw pad goes through a two-flop synchroniser. The FSM only looks at the
// second flop. A press is accepted after the synchronised key has read 0 for
// a full stability window. A release is accepted after the same window of
// stable 1 samples, and it re-arms the next press. Each accepted press gives
// a key_ok pulse that is one clock wide.
//
// Optional feature macro: KEY_XD_RELEASE_EN
//   defined   : key_rel port exists and pulses once per accepted release.
//   undefined : key_rel port is absent and an accepted release is silent.
//
// Parameters
//   CNT_MAX  stability window in clk cycles (legal >= 2)
//   CNT_W    counter width, 2**CNT_W > CNT_MAX
//
// Ports
//   clk      in   system clock, every register uses the rising edge
//   rst_n    in   synchronous reset, active HIGH (1 = reset); the name is
//                 kept as the existing codebase uses it
//   key      in   raw asynchronous key pad, 0 = pressed
//   key_ok   out  registered one-cycle pulse per debounced press
//   key_rel  out  registered one-cycle pulse per debounced release
//                 (only when KEY_XD_RELEASE_EN is defined)
// -----------------------------------------------------------------------------
module key_xd #(
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic key_ok
`ifdef KEY_XD_RELEASE_EN
   ,output logic key_rel
`endif
);

    // state   | meaning
    // IDLE    | key released and stable, waiting for a 0 sample
    // FILT_DN | key reads 0, counting the stable samples of the press window
    // PRESSED | press accepted, waiting for a 1 sample
    // FILT_UP | key reads 1, counting the stable samples of the release window
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        PRESSED = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    state_t           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ok_q;
`ifdef KEY_XD_RELEASE_EN
    logic             rel_q;
`endif

    logic cnt_done;
    assign cnt_done = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            // Sync flops preset to "released" so that leaving reset does not
            // look like a press edge.
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
`ifdef KEY_XD_RELEASE_EN
            rel_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            ok_q    <= 1'b0;
`ifdef KEY_XD_RELEASE_EN
            rel_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!sync2_q) begin
                        state_q <= FILT_DN;
                        cnt_q   <= '0;
                    end
                end
                FILT_DN: begin
                    if (sync2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        ok_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    // A held key stays here. Only a release can re-arm key_ok.
                    if (sync2_q) begin
                        state_q <= FILT_UP;
                        cnt_q   <= '0;
                    end
                end
                FILT_UP: begin
                    if (!sync2_q) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_done) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
`ifdef KEY_XD_RELEASE_EN
                        rel_q   <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign key_ok  = ok_q;
`ifdef KEY_XD_RELEASE_EN
    assign key_rel = rel_q;
`endif

endmodule

// File: tb/tb_key_xd.sv
module tb_key_xd;

    logic clk;
    logic rst_n;
    logic key;
    logic key_ok;
    logic ok_s;
`ifdef KEY_XD_RELEASE_EN
    logic key_rel;
    logic rel_s;
`endif

    key_xd #(.CNT_MAX(1000), .CNT_W(10)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key    (key),
        .key_ok (key_ok)
`ifdef KEY_XD_RELEASE_EN
       ,.key_rel(key_rel)
`endif
    );

    // Minimum legal window, driven by the same stimulus
    key_xd #(.CNT_MAX(2), .CNT_W(2)) u_small (
        .clk    (clk),
        .rst_n  (rst_n),
        .key    (key),
        .key_ok (ok_s)
`ifdef KEY_XD_RELEASE_EN
       ,.key_rel(rel_s)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural model: two cycles of sync delay, then a debounced level.
    // The level flips once CNT_MAX+1 consecutive samples disagree with it.
    typedef struct packed {
        logic s1;
        logic s2;
        logic pressed;
        int   run;
        logic ok;
        logic rel;
    } mdl_t;

    function automatic mdl_t mstep(mdl_t m, logic k, logic rst, int cmax);
        mdl_t n;
        logic smp;
        n     = m;
        n.ok  = 1'b0;
        n.rel = 1'b0;
        if (rst) begin
            n.s1      = 1'b1;
            n.s2      = 1'b1;
            n.pressed = 1'b0;
            n.run     = 0;
        end else begin
            smp  = m.s2;
            n.s1 = k;
            n.s2 = m.s1;
            if ((smp == 1'b0) != m.pressed) begin
                n.run = m.run + 1;
                if (n.run == cmax + 1) begin
                    n.pressed = ~m.pressed;
                    n.run     = 0;
                    if (n.pressed) n.ok = 1'b1;
                    else           n.rel = 1'b1;
                end
            end else begin
                n.run = 0;
            end
        end
        return n;
    endfunction

    mdl_t m_main = '{s1: 1'b1, s2: 1'b1, pressed: 1'b0, run: 0, ok: 1'b0, rel: 1'b0};
    mdl_t m_small = '{s1: 1'b1, s2: 1'b1, pressed: 1'b0, run: 0, ok: 1'b0, rel: 1'b0};

    int   cyc = 0;
    bit   armed = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   ok_total = 0;
    int   ok_s_total = 0;
    int   rel_total = 0;
    int   last_ok_cyc = -1;
    int   last_ok_s_cyc = -1;

    always @(posedge clk) begin
        cyc++;
        m_main  = mstep(m_main, key, rst_n, 1000);
        m_small = mstep(m_small, key, rst_n, 2);
        if (rst_n) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            total++;
            if (key_ok !== m_main.ok) begin
                bad++;
                $display("FAIL key_ok cyc=%0d got=%b exp=%b", cyc, key_ok, m_main.ok);
            end
            total++;
            if (ok_s !== m_small.ok) begin
                bad++;
                $display("FAIL ok_small cyc=%0d got=%b exp=%b", cyc, ok_s, m_small.ok);
            end
`ifdef KEY_XD_RELEASE_EN
            total++;
            if (key_rel !== m_main.rel) begin
                bad++;
                $display("FAIL key_rel cyc=%0d got=%b exp=%b", cyc, key_rel, m_main.rel);
            end
            total++;
            if (rel_s !== m_small.rel) begin
                bad++;
                $display("FAIL rel_small cyc=%0d got=%b exp=%b", cyc, rel_s, m_small.rel);
            end
            if (key_rel === 1'b1) rel_total++;
`endif
            if (key_ok === 1'b1) begin
                ok_total++;
                last_ok_cyc = cyc;
            end
            if (ok_s === 1'b1) begin
                ok_s_total++;
                last_ok_s_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int s_ok, s_oks, s_rel, start, r_edge;

    initial begin
        rst_n = 1'b1;
        key   = 1'b1;
        wait_cyc(6);
        chk("reset_ok", int'(key_ok), 0);
        chk("reset_pulses", ok_total, 0);
        rst_n = 1'b0;
        wait_cyc(20);
        chk("post_reset_pulses", ok_total + rel_total, 0);

        // Bounce: 0 for 100, 1 for 100, 0 for 500, then released
        s_ok = ok_total;
        key = 1'b0; wait_cyc(100);
        key = 1'b1; wait_cyc(100);
        key = 1'b0; wait_cyc(500);
        key = 1'b1; wait_cyc(1200);
        chk("bounce_no_ok", ok_total - s_ok, 0);

        // Clean press held for 5000 cycles
        s_ok  = ok_total;
        s_oks = ok_s_total;
        key   = 1'b0;
        start = cyc + 1;
        wait_cyc(5000);
        chk("press_count", ok_total - s_ok, 1);
        chk("press_latency", last_ok_cyc - start, 1002);
        chk("small_press_count", ok_s_total - s_oks, 1);
        chk("small_press_latency", last_ok_s_cyc - start, 4);

        // Release, then re-press
        s_ok  = ok_total;
        s_rel = rel_total;
        key   = 1'b1;
        wait_cyc(1200);
        chk("release_no_ok", ok_total - s_ok, 0);
`ifdef KEY_XD_RELEASE_EN
        chk("release_rel", rel_total - s_rel, 1);
`endif
        key   = 1'b0;
        start = cyc + 1;
        wait_cyc(1500);
        chk("repress_count", ok_total - s_ok, 1);
        chk("repress_latency", last_ok_cyc - start, 1002);

        // Release glitch while pressed
        s_ok  = ok_total;
        s_oks = ok_s_total;
        s_rel = rel_total;
        key = 1'b1; wait_cyc(50);
        key = 1'b0; wait_cyc(1200);
        chk("glitch_no_ok", ok_total - s_ok, 0);
        chk("glitch_no_rel", rel_total - s_rel, 0);
        chk("small_glitch_ok", ok_s_total - s_oks, 1);

        // Reset in the middle of the press window
        key = 1'b1; wait_cyc(1200);
        key = 1'b0; wait_cyc(600);
        s_ok  = ok_total;
        rst_n = 1'b1;
        wait_cyc(2);
        r_edge = cyc;
        rst_n  = 1'b0;
        wait_cyc(1002);
        chk("rst_mid_no_early", ok_total - s_ok, 0);
        wait_cyc(100);
        chk("rst_mid_count", ok_total - s_ok, 1);
        chk("rst_mid_latency", last_ok_cyc - r_edge, 1003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
